ibex_branch_resolve_unit: RTL

Consumer end of the branch ALU interface. Accepts a branch or jump from ID and captures the same-cycle comparison result. It then takes the branch target, which the branch ALU registers and so delivers one cycle later. It resolves taken/not-taken, checks alignment, and drives a valid/ready PC-redirect request to the IF stage, plus link address, exception and performance pulses.

---
 rtl/ibex_pkg.sv | 25 ++
 rtl/ibex_sat_counter.sv | 26 ++
 rtl/ibex_branch_resolve_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the branch resolution slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package ibex_pkg;

    // Control-transfer class presented by ID; encoding 3 is reserved.
    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JAL  = 2'd1,
        BR_JALR = 2'd2
    } br_type_e;

    // Resolve FSM states.
    typedef enum logic [1:0] {
        BR_IDLE     = 2'd0,
        BR_WAIT_TGT = 2'd1,
        BR_REDIRECT = 2'd2
    } br_res_state_e;

    // Sequential PC increment for the link address.
    function automatic logic [31:0] link_addr(input logic [31:0] pc, input logic compressed);
        return pc + (compressed ? 32'd2 : 32'd4);
    endfunction

endpackage

// File: rtl/ibex_sat_counter.sv
// Saturating event counter, cleared only by reset.
// Latency: count reflects an increment one cycle after inc_i.
// Backpressure: none; holds at all-ones instead of wrapping.
module ibex_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    // Count up on each event until all-ones is reached.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_branch_resolve_unit.sv
// Resolves branches/jumps from ID and issues PC redirects to IF.
// Latency: not-taken resolves 1 cycle after accept; taken redirect offered 2 cycles after accept.
// Backpressure: redirect held until IF ready; ID stalled (br_ready_o=0) outside IDLE.
module ibex_branch_resolve_unit import ibex_pkg::*; #(
    parameter bit          CompressedEn = 1'b1,
    parameter int unsigned ResolveCntW  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   br_valid_i,
    output logic                   br_ready_o,
    input  logic [1:0]             br_type_i,
    input  logic [31:0]            br_pc_i,
    input  logic                   br_compressed_i,
    input  logic                   cmp_result_i,
    input  logic [31:0]            adder_result_i,
    input  logic                   flush_i,
    output logic                   redirect_valid_o,
    input  logic                   redirect_ready_i,
    output logic [31:0]            redirect_pc_o,
    output logic [31:0]            link_addr_o,
    output logic                   done_o,
    output logic                   exc_misaligned_o,
    output logic [31:0]            exc_tval_o,
    output logic                   perf_branch_o,
    output logic                   perf_tbranch_o,
    output logic [ResolveCntW-1:0] resolved_cnt_o,
    output logic [ResolveCntW-1:0] taken_cnt_o
);

    br_res_state_e state_q, state_d;
    logic          is_cond_q;
    logic          taken_q;
    logic [31:0]   link_q;
    logic [31:0]   redirect_pc_q;
    logic [31:0]   target;
    logic          misaligned;
    logic          accept;
    logic          load_redirect;

    // Target arrives registered from the branch ALU; bit0 is always dropped.
    assign target     = adder_result_i & ~32'd1;
    // Without compressed support a halfword-aligned target is illegal.
    assign misaligned = (CompressedEn == 1'b0) && target[1];
    assign accept     = br_valid_i && br_ready_o;

    // Next-state and per-cycle outputs; flush wins over everything.
    always_comb begin
        state_d          = state_q;
        br_ready_o       = 1'b0;
        redirect_valid_o = 1'b0;
        done_o           = 1'b0;
        exc_misaligned_o = 1'b0;
        perf_branch_o    = 1'b0;
        perf_tbranch_o   = 1'b0;
        load_redirect    = 1'b0;
        unique case (state_q)
            BR_IDLE: begin
                br_ready_o = ~flush_i;
                if (br_valid_i && !flush_i) begin
                    state_d = BR_WAIT_TGT;
                end
            end
            BR_WAIT_TGT: begin
                state_d = BR_IDLE;
                if (!flush_i) begin
                    if (!taken_q) begin
                        done_o        = 1'b1;
                        perf_branch_o = is_cond_q;
                    end else if (misaligned) begin
                        exc_misaligned_o = 1'b1;
                        perf_branch_o    = is_cond_q;
                    end else begin
                        load_redirect = 1'b1;
                        state_d       = BR_REDIRECT;
                    end
                end
            end
            BR_REDIRECT: begin
                redirect_valid_o = ~flush_i;
                if (flush_i) begin
                    state_d = BR_IDLE;
                end else if (redirect_ready_i) begin
                    done_o         = 1'b1;
                    perf_branch_o  = is_cond_q;
                    perf_tbranch_o = is_cond_q;
                    state_d        = BR_IDLE;
                end
            end
            default: state_d = BR_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture instruction attributes at accept and the redirect target once resolved.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_cond_q     <= 1'b0;
            taken_q       <= 1'b0;
            link_q        <= '0;
            redirect_pc_q <= '0;
        end else begin
            if (accept) begin
                is_cond_q <= (br_type_i == BR_COND);
                taken_q   <= (br_type_i == BR_JAL) || (br_type_i == BR_JALR) ||
                             ((br_type_i == BR_COND) && cmp_result_i);
                link_q    <= link_addr(br_pc_i, br_compressed_i);
            end
            if (load_redirect) begin
                redirect_pc_q <= target;
            end
        end
    end

    assign redirect_pc_o = redirect_pc_q;
    assign link_addr_o   = link_q;
    assign exc_tval_o    = exc_misaligned_o ? target : 32'd0;

    ibex_sat_counter #(
        .Width(ResolveCntW)
    ) u_resolved_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (perf_branch_o),
        .cnt_o (resolved_cnt_o)
    );

    ibex_sat_counter #(
        .Width(ResolveCntW)
    ) u_taken_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (perf_tbranch_o),
        .cnt_o (taken_cnt_o)
    );

endmodule
